// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store engine and the control unit.
//   op_e    : memory op-codes (LW..SB) as issued by the control unit
//   state_e : FSM state encodings of mem_access_unit
//   is_load / is_misaligned : op classification helpers
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LB  = 3'b010,
        OP_LHU = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    function automatic logic is_load(input op_e op);
        return !(op inside {OP_SW, OP_SH, OP_SB});
    endfunction

    // Word ops need a 4-byte boundary, half ops a 2-byte boundary.
    function automatic logic is_misaligned(input op_e op, input logic [1:0] lane);
        case (op)
            OP_LW, OP_SW:         return lane != 2'b00;
            OP_LH, OP_LHU, OP_SH: return lane[0];
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane_unit.sv
// Combinational little-endian lane handling.
//   op         in  : memory op-code
//   lane       in  : addr[1:0] of the access
//   word       in  : full memory word (read data)
//   store_data in  : register value to store
//   load_ext   out : addressed byte/half, sign- or zero-extended (LW: word as-is)
//   store_word out : word with the addressed lane replaced (SW: store_data)
module byte_lane_unit
    import mem_access_unit_pkg::*;
(
    input  op_e         op,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] store_data,
    output logic [31:0] load_ext,
    output logic [31:0] store_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        sel_byte = word[7:0];
        case (lane)
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            2'd3:    sel_byte = word[31:24];
            default: sel_byte = word[7:0];
        endcase
        sel_half = lane[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_ext = word;
        case (op)
            OP_LB:   load_ext = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_ext = {24'h0, sel_byte};
            OP_LH:   load_ext = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_ext = {16'h0, sel_half};
            default: load_ext = word;
        endcase
    end

    always_comb begin
        store_word = word;
        case (op)
            OP_SW: store_word = store_data;
            OP_SH: store_word = lane[1] ? {store_data[15:0], word[15:0]}
                                        : {word[31:16], store_data[15:0]};
            OP_SB: begin
                case (lane)
                    2'd0:    store_word = {word[31:8], store_data[7:0]};
                    2'd1:    store_word = {word[31:16], store_data[7:0], word[7:0]};
                    2'd2:    store_word = {word[31:24], store_data[7:0], word[15:0]};
                    default: store_word = {store_data[7:0], word[23:0]};
                endcase
            end
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle load/store engine between the control unit and data memory.
// Word-aligned reads/writes, read-modify-write for SH/SB, misalignment reporting.
//   clk, reset_n         : clock, async active-low reset
//   start, op, addr,
//   store_data           : request from the control unit (sampled in IDLE only)
//   mem_addr, mem_wr,
//   mem_wdata, mem_rdata : data memory interface (word address)
//   mem_out, mem_ext_out : raw and extended result of the last completed load
//   busy, done, misalign : status to the control unit
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_out,
    output logic [31:0] mem_ext_out,
    output logic        busy,
    output logic        done,
    output logic        misalign
);

    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] LAT = CW'(MEM_LATENCY);

    state_e        state_q;
    op_e           op_q;
    logic [31:0]   addr_q, store_data_q, rdata_q;
    logic [CW-1:0] cnt_q;
    logic          mem_wr_q, busy_q, done_q, misalign_q;
    logic [31:0]   mem_out_q, mem_ext_q;

    logic [31:0]   lane_word, load_ext, store_word;
    op_e           op_in;

    assign op_in = op_e'(op);

    // During READ the lane unit extends the word arriving from memory; during
    // WRITE it merges into the word captured at the end of READ.
    assign lane_word = (state_q == ST_READ) ? mem_rdata : rdata_q;

    byte_lane_unit u_lane (
        .op         (op_q),
        .lane       (addr_q[1:0]),
        .word       (lane_word),
        .store_data (store_data_q),
        .load_ext   (load_ext),
        .store_word (store_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_LW;
            addr_q       <= '0;
            store_data_q <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
            mem_wr_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            misalign_q   <= 1'b0;
            mem_out_q    <= '0;
            mem_ext_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values; the pulse defaults below are
            // overridden by later assignments in the same block.
            mem_wr_q   <= 1'b0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q         <= op_in;
                        addr_q       <= addr;
                        store_data_q <= store_data;
                        busy_q       <= 1'b1;
                        if (is_misaligned(op_in, addr[1:0])) begin
                            misalign_q <= 1'b1;
                            state_q    <= ST_ERR;
                        end else if (op_in == OP_SW) begin
                            mem_wr_q <= 1'b1;
                            state_q  <= ST_WRITE;
                        end else begin
                            cnt_q   <= LAT;
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (cnt_q == CW'(1)) begin
                        rdata_q <= mem_rdata;
                        if (is_load(op_q)) begin
                            mem_out_q <= mem_rdata;
                            mem_ext_q <= load_ext;
                            done_q    <= 1'b1;
                            state_q   <= ST_DONE;
                        end else begin
                            mem_wr_q <= 1'b1;
                            state_q  <= ST_WRITE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_WRITE: begin
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE, ST_ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr    = (state_q inside {ST_READ, ST_WRITE, ST_DONE}) ? {addr_q[31:2], 2'b00} : '0;
    assign mem_wdata   = (state_q == ST_WRITE) ? store_word : '0;
    assign mem_wr      = mem_wr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign misalign    = misalign_q;
    assign mem_out     = mem_out_q;
    assign mem_ext_out = mem_ext_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one instance at MEM_LATENCY=1, one at 3.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, start3;
    logic [2:0]  op;
    logic [31:0] addr, store_data, mem_rdata;

    logic [31:0] mem_addr, mem_wdata, mem_out, mem_ext_out;
    logic        mem_wr, busy, done, misalign;
    logic [31:0] mem_addr3, mem_wdata3, mem_out3, mem_ext_out3;
    logic        mem_wr3, busy3, done3, misalign3;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .addr(addr),
        .store_data(store_data), .mem_addr(mem_addr), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_out(mem_out),
        .mem_ext_out(mem_ext_out), .busy(busy), .done(done), .misalign(misalign)
    );

    mem_access_unit #(.MEM_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .op(op), .addr(addr),
        .store_data(store_data), .mem_addr(mem_addr3), .mem_wr(mem_wr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata), .mem_out(mem_out3),
        .mem_ext_out(mem_ext_out3), .busy(busy3), .done(done3), .misalign(misalign3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; start3 = 1'b0;
        op = 3'b000; addr = '0; store_data = '0; mem_rdata = '0;
        #3;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst mem_wr", 32'(mem_wr), 32'd0);
        check("rst misalign", 32'(misalign), 32'd0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        check("rst mem_out", mem_out, 32'h0);
        check("rst mem_ext_out", mem_ext_out, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // LW 0x104
        op = OP_LW; addr = 32'h104; mem_rdata = 32'hDEADBEEF; start = 1'b1;
        tick(); start = 1'b0;
        check("lw s1 busy", 32'(busy), 32'd1);
        check("lw s1 done", 32'(done), 32'd0);
        check("lw s1 mem_addr", mem_addr, 32'h104);
        check("lw s1 mem_wr", 32'(mem_wr), 32'd0);
        tick();
        check("lw s2 done", 32'(done), 32'd1);
        check("lw s2 mem_wr", 32'(mem_wr), 32'd0);
        check("lw mem_out", mem_out, 32'hDEADBEEF);
        check("lw mem_ext_out", mem_ext_out, 32'hDEADBEEF);
        tick();
        check("lw s3 done", 32'(done), 32'd0);
        check("lw s3 busy", 32'(busy), 32'd0);
        check("lw s3 mem_addr", mem_addr, 32'h0);

        // LB / LBU 0x103
        op = OP_LB; addr = 32'h103; mem_rdata = 32'h80112233; start = 1'b1;
        tick(); start = 1'b0;
        check("lb s1 mem_addr", mem_addr, 32'h100);
        tick();
        check("lb done", 32'(done), 32'd1);
        check("lb mem_ext_out", mem_ext_out, 32'hFFFFFF80);
        check("lb mem_out", mem_out, 32'h80112233);
        tick();
        op = OP_LBU; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        check("lbu mem_ext_out", mem_ext_out, 32'h00000080);
        tick();

        // LH / LHU 0x102
        op = OP_LH; addr = 32'h102; mem_rdata = 32'h8001AAAA; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        check("lh mem_ext_out", mem_ext_out, 32'hFFFF8001);
        tick();
        op = OP_LHU; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        check("lhu mem_ext_out", mem_ext_out, 32'h00008001);
        check("lhu mem_out", mem_out, 32'h8001AAAA);
        tick();

        // SH 0x102 over 0x11223344
        op = OP_SH; addr = 32'h102; store_data = 32'h0000ABCD; mem_rdata = 32'h11223344; start = 1'b1;
        tick(); start = 1'b0;
        check("sh s1 mem_wr", 32'(mem_wr), 32'd0);
        check("sh s1 mem_addr", mem_addr, 32'h100);
        tick();
        check("sh s2 mem_wr", 32'(mem_wr), 32'd1);
        check("sh s2 mem_wdata", mem_wdata, 32'hABCD3344);
        check("sh s2 done", 32'(done), 32'd0);
        tick();
        check("sh s3 done", 32'(done), 32'd1);
        check("sh s3 mem_wr", 32'(mem_wr), 32'd0);
        check("sh s3 mem_wdata", mem_wdata, 32'h0);
        check("sh keeps mem_out", mem_out, 32'h8001AAAA);
        tick();

        // SB 0x101, with a second start pulsed mid-operation
        op = OP_SB; addr = 32'h101; store_data = 32'h000000EE; start = 1'b1;
        tick();
        op = OP_LW; addr = 32'h200;
        tick(); start = 1'b0;
        check("sb s2 mem_wr", 32'(mem_wr), 32'd1);
        check("sb s2 mem_wdata", mem_wdata, 32'h1122EE44);
        check("sb s2 mem_addr", mem_addr, 32'h100);
        tick();
        check("sb s3 done", 32'(done), 32'd1);
        tick();
        check("ignored start busy", 32'(busy), 32'd0);
        check("ignored start mem_addr", mem_addr, 32'h0);

        // Misaligned LW 0x106
        op = OP_LW; addr = 32'h106; start = 1'b1;
        tick(); start = 1'b0;
        check("mis s1 misalign", 32'(misalign), 32'd1);
        check("mis s1 busy", 32'(busy), 32'd1);
        check("mis s1 mem_wr", 32'(mem_wr), 32'd0);
        check("mis s1 mem_addr", mem_addr, 32'h0);
        tick();
        check("mis s2 misalign", 32'(misalign), 32'd0);
        check("mis s2 busy", 32'(busy), 32'd0);
        check("mis s2 done", 32'(done), 32'd0);
        check("mis keeps mem_out", mem_out, 32'h8001AAAA);

        // SW 0x100
        op = OP_SW; addr = 32'h100; store_data = 32'h12345678; start = 1'b1;
        tick(); start = 1'b0;
        check("sw s1 mem_wr", 32'(mem_wr), 32'd1);
        check("sw s1 mem_wdata", mem_wdata, 32'h12345678);
        check("sw s1 mem_addr", mem_addr, 32'h100);
        tick();
        check("sw s2 done", 32'(done), 32'd1);
        check("sw s2 mem_wr", 32'(mem_wr), 32'd0);
        tick();

        // Reset asserted during WRITE
        op = OP_SW; addr = 32'h108; store_data = 32'hCAFEF00D; start = 1'b1;
        tick(); start = 1'b0;
        check("rw s1 mem_wr", 32'(mem_wr), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("rw mem_wr", 32'(mem_wr), 32'd0);
        check("rw busy", 32'(busy), 32'd0);
        check("rw done", 32'(done), 32'd0);
        check("rw mem_addr", mem_addr, 32'h0);
        check("rw mem_wdata", mem_wdata, 32'h0);
        check("rw mem_out", mem_out, 32'h0);
        check("rw mem_ext_out", mem_ext_out, 32'h0);
        reset_n = 1'b1;
        tick();
        check("after rst busy", 32'(busy), 32'd0);

        // LW 0x104 with MEM_LATENCY=3
        op = OP_LW; addr = 32'h104; mem_rdata = 32'hDEADBEEF; start3 = 1'b1;
        tick(); start3 = 1'b0;
        check("lat3 s1 busy", 32'(busy3), 32'd1);
        check("lat3 s1 done", 32'(done3), 32'd0);
        check("lat3 s1 mem_addr", mem_addr3, 32'h104);
        tick();
        check("lat3 s2 done", 32'(done3), 32'd0);
        tick();
        check("lat3 s3 done", 32'(done3), 32'd0);
        tick();
        check("lat3 s4 done", 32'(done3), 32'd1);
        check("lat3 mem_out", mem_out3, 32'hDEADBEEF);
        check("lat3 other dut idle", 32'(busy), 32'd0);
        tick();
        check("lat3 s5 busy", 32'(busy3), 32'd0);
        check("lat3 s5 done", 32'(done3), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
